step_sequencer: RTL and testbench

- Multicycle control front end of the 16-bit RISC core. It owns the instruction register (IR), the step counter Cnt and the processor status word (PSW).
- Its outputs feed the instruction decoder: InsM, InsL, Cnt and PSW_NZC.
- It consumes the decoder's Buff_MEMIns, Buff_PSW and Done strobes, plus the ALU flags.
- It decides per instruction class how many steps run before Cnt returns to 0, and parks the core on HALT.

---
 rtl/step_sequencer.sv | 128 ++++++++++++
 tb/tb_step_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// step_sequencer: multicycle control front end of the 16-bit RISC core.
// Holds the instruction register, the step counter and the NZC status word,
// and picks the step count for each instruction class from the latched IR.
module step_sequencer #(
    parameter logic [15:0] RESET_IR  = 16'h0000,
    parameter logic [2:0]  LAST_STEP = 3'd4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic        Stall,
    input  logic [15:0] MemData,
    input  logic        Buff_MEMIns,
    input  logic        Buff_PSW,
    input  logic        Done,
    input  logic [2:0]  ALU_NZC,
    output logic [15:0] Ins,
    output logic [7:0]  InsM,
    output logic [1:0]  InsL,
    output logic [2:0]  Cnt,
    output logic [2:0]  PSW,
    output logic [1:0]  PSW_NZC,
    output logic        Running,
    output logic        Halted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] ir_q, ir_d;
    logic [2:0]  psw_q, psw_d;
    logic        running_q, halted_q;

    logic        is_sys;
    logic        is_halt;
    logic        short_len;
    logic        done_window;
    logic [2:0]  cnt_step;

    // Instruction class decode from the latched IR (valid from Cnt=1 on).
    always_comb begin
        is_sys      = (ir_q[15:11] == 5'b11100);
        is_halt     = is_sys && (ir_q[1:0] == 2'b01);
        short_len   = (ir_q[15] && !is_sys) || (is_sys && (ir_q[1:0] == 2'b00));
        done_window = is_halt && ((cnt_q == 3'd2) || (cnt_q == 3'd3));
    end

    // Next step index: wrap at LAST_STEP, short instructions return after step 1.
    always_comb begin
        cnt_step = cnt_q + 3'd1;
        if (cnt_q >= LAST_STEP) begin
            cnt_step = '0;
        end else if ((cnt_q == 3'd1) && short_len) begin
            cnt_step = '0;
        end
    end

    // Next-state logic for the sequencer, IR and PSW.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ir_d    = ir_q;
        psw_d   = psw_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (Start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!Stall && Buff_PSW) begin
                    psw_d = ALU_NZC;
                end
                // Done wins over Stall; Cnt stays on the step where HALT was seen.
                if (Done && done_window) begin
                    state_d = S_HALT;
                end else if (!Stall) begin
                    if (Buff_MEMIns && (cnt_q == 3'd0)) begin
                        ir_d = MemData;
                    end
                    cnt_d = cnt_step;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, IR, PSW and status flag registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ir_q      <= RESET_IR;
            psw_q     <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ir_q      <= ir_d;
            psw_q     <= psw_d;
            running_q <= (state_d == S_RUN);
            halted_q  <= (state_d == S_HALT);
        end
    end

    assign Ins     = ir_q;
    assign InsM    = ir_q[15:8];
    assign InsL    = ir_q[1:0];
    assign Cnt     = cnt_q;
    assign PSW     = psw_q;
    assign PSW_NZC = psw_q[1:0];
    assign Running = running_q;
    assign Halted  = halted_q;

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed vector table plus hand-written multi-cycle
// sequences for the step sequencer.
module tb_step_sequencer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Start = 1'b0;
    logic        Stall = 1'b0;
    logic [15:0] MemData = '0;
    logic        Buff_MEMIns = 1'b0;
    logic        Buff_PSW = 1'b0;
    logic        Done = 1'b0;
    logic [2:0]  ALU_NZC = '0;
    logic [15:0] Ins;
    logic [7:0]  InsM;
    logic [1:0]  InsL;
    logic [2:0]  Cnt;
    logic [2:0]  PSW;
    logic [1:0]  PSW_NZC;
    logic        Running;
    logic        Halted;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    step_sequencer #(.RESET_IR(16'h0000), .LAST_STEP(3'd4)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Stall(Stall), .MemData(MemData),
        .Buff_MEMIns(Buff_MEMIns), .Buff_PSW(Buff_PSW), .Done(Done),
        .ALU_NZC(ALU_NZC), .Ins(Ins), .InsM(InsM), .InsL(InsL), .Cnt(Cnt),
        .PSW(PSW), .PSW_NZC(PSW_NZC), .Running(Running), .Halted(Halted)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst, start, stall, bmem, bpsw, done;
        logic [15:0] mem;
        logic [2:0]  nzc;
        logic [2:0]  e_cnt;
        logic [15:0] e_ins;
        logic [2:0]  e_psw;
        logic        e_run, e_halt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, start, stall, bmem, bpsw, done,
                       input logic [15:0] mem, input logic [2:0] nzc,
                       input logic [2:0] e_cnt, input logic [15:0] e_ins,
                       input logic [2:0] e_psw, input logic e_run, e_halt);
        vec_t v;
        v.rst = rst; v.start = start; v.stall = stall; v.bmem = bmem;
        v.bpsw = bpsw; v.done = done; v.mem = mem; v.nzc = nzc;
        v.e_cnt = e_cnt; v.e_ins = e_ins; v.e_psw = e_psw;
        v.e_run = e_run; v.e_halt = e_halt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        else
            n_pass++;
    endtask

    task automatic check_all(input int idx, input logic [2:0] e_cnt,
                             input logic [15:0] e_ins, input logic [2:0] e_psw,
                             input logic e_run, input logic e_halt);
        chk("Cnt", idx, {13'd0, Cnt}, {13'd0, e_cnt});
        chk("Ins", idx, Ins, e_ins);
        chk("InsM", idx, {8'd0, InsM}, {8'd0, e_ins[15:8]});
        chk("InsL", idx, {14'd0, InsL}, {14'd0, e_ins[1:0]});
        chk("PSW", idx, {13'd0, PSW}, {13'd0, e_psw});
        chk("PSW_NZC", idx, {14'd0, PSW_NZC}, {14'd0, e_psw[1:0]});
        chk("Running", idx, {15'd0, Running}, {15'd0, e_run});
        chk("Halted", idx, {15'd0, Halted}, {15'd0, e_halt});
    endtask

    task automatic drive(input logic rst, start, stall, bmem, bpsw, done,
                         input logic [15:0] mem, input logic [2:0] nzc);
        Rst = rst; Start = start; Stall = stall; Buff_MEMIns = bmem;
        Buff_PSW = bpsw; Done = done; MemData = mem; ALU_NZC = nzc;
    endtask

    logic [2:0] m_cnt;
    int         budget;

    initial begin
        //  rst st sl bm bp dn  mem       nzc  | cnt  ins       psw  run hlt
        add(1, 0, 0, 0, 0, 0, 16'h0000, 3'd0, 3'd0, 16'h0000, 3'd0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 16'h0000, 3'd0, 3'd0, 16'h0000, 3'd0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 16'h0001, 3'd0, 3'd0, 16'h0000, 3'd0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 16'h0001, 3'd0, 3'd1, 16'h0001, 3'd0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 16'hFFFF, 3'd0, 3'd2, 16'h0001, 3'd0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 16'hFFFF, 3'd3, 3'd3, 16'h0001, 3'd3, 1, 0);
        add(0, 0, 1, 0, 1, 0, 16'h0001, 3'd5, 3'd3, 16'h0001, 3'd3, 1, 0);
        add(0, 0, 0, 0, 0, 0, 16'h0001, 3'd0, 3'd4, 16'h0001, 3'd3, 1, 0);
        add(0, 0, 0, 0, 0, 0, 16'h0001, 3'd0, 3'd0, 16'h0001, 3'd3, 1, 0);
        add(0, 0, 0, 1, 0, 0, 16'h9000, 3'd0, 3'd1, 16'h9000, 3'd3, 1, 0);
        add(0, 0, 0, 1, 0, 0, 16'h1234, 3'd0, 3'd0, 16'h9000, 3'd3, 1, 0);
        add(0, 0, 0, 1, 0, 0, 16'h9000, 3'd0, 3'd1, 16'h9000, 3'd3, 1, 0);
        add(0, 0, 1, 1, 0, 0, 16'h1234, 3'd0, 3'd1, 16'h9000, 3'd3, 1, 0);
        add(0, 0, 1, 1, 0, 0, 16'h1234, 3'd0, 3'd1, 16'h9000, 3'd3, 1, 0);
        add(0, 0, 1, 1, 0, 0, 16'h1234, 3'd0, 3'd1, 16'h9000, 3'd3, 1, 0);
        add(0, 0, 0, 0, 0, 0, 16'h1234, 3'd0, 3'd0, 16'h9000, 3'd3, 1, 0);
        add(0, 0, 0, 1, 0, 0, 16'h0001, 3'd0, 3'd1, 16'h0001, 3'd3, 1, 0);
        add(0, 0, 0, 0, 0, 0, 16'h0001, 3'd0, 3'd2, 16'h0001, 3'd3, 1, 0);
        add(0, 0, 0, 0, 0, 0, 16'h0001, 3'd0, 3'd3, 16'h0001, 3'd3, 1, 0);
        add(1, 1, 0, 1, 1, 0, 16'hFFFF, 3'd7, 3'd0, 16'h0000, 3'd0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 16'hE001, 3'd0, 3'd0, 16'h0000, 3'd0, 1, 0);
        add(0, 0, 1, 1, 1, 0, 16'hE001, 3'd3, 3'd0, 16'h0000, 3'd0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 16'hE001, 3'd0, 3'd1, 16'hE001, 3'd0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 16'hE001, 3'd0, 3'd2, 16'hE001, 3'd0, 1, 0);
        add(0, 0, 1, 0, 0, 1, 16'hE001, 3'd0, 3'd2, 16'hE001, 3'd0, 0, 1);
        add(0, 1, 0, 1, 1, 0, 16'h0000, 3'd7, 3'd2, 16'hE001, 3'd0, 0, 1);
        add(0, 1, 0, 0, 0, 1, 16'h0000, 3'd0, 3'd2, 16'hE001, 3'd0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 16'h0000, 3'd0, 3'd0, 16'h0000, 3'd0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 16'h0000, 3'd0, 3'd0, 16'h0000, 3'd0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 16'h0000, 3'd0, 3'd0, 16'h0000, 3'd0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 16'hE000, 3'd0, 3'd1, 16'hE000, 3'd0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 16'hE000, 3'd0, 3'd0, 16'hE000, 3'd0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 16'hE001, 3'd0, 3'd1, 16'hE001, 3'd0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 16'hE001, 3'd0, 3'd2, 16'hE001, 3'd0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 16'hE001, 3'd0, 3'd3, 16'hE001, 3'd0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 16'hE001, 3'd0, 3'd4, 16'hE001, 3'd0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 16'hE001, 3'd0, 3'd0, 16'hE001, 3'd0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 16'hE002, 3'd0, 3'd1, 16'hE002, 3'd0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 16'hE002, 3'd0, 3'd2, 16'hE002, 3'd0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 16'hE002, 3'd0, 3'd3, 16'hE002, 3'd0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 16'hE002, 3'd0, 3'd4, 16'hE002, 3'd0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 16'hE002, 3'd0, 3'd0, 16'hE002, 3'd0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 16'hE001, 3'd0, 3'd1, 16'hE001, 3'd0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 16'hE001, 3'd0, 3'd2, 16'hE001, 3'd0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 16'hE001, 3'd0, 3'd3, 16'hE001, 3'd0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 16'hE001, 3'd0, 3'd3, 16'hE001, 3'd0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 16'h0000, 3'd0, 3'd0, 16'h0000, 3'd0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].stall, vecs[i].bmem,
                  vecs[i].bpsw, vecs[i].done, vecs[i].mem, vecs[i].nzc);
            @(posedge Clk);
            #1;
            check_all(i, vecs[i].e_cnt, vecs[i].e_ins, vecs[i].e_psw,
                      vecs[i].e_run, vecs[i].e_halt);
        end

        // Full-class instruction under random stalls: Cnt only advances when
        // not stalled and never goes past 4.
        drive(0, 1, 0, 0, 0, 0, 16'h0001, 3'd0);
        @(posedge Clk); #1;
        m_cnt = 3'd0;
        for (int i = 0; i < 60; i++) begin
            drive(0, 0, ($urandom_range(0, 2) == 0), 1'b1, 0, 0, 16'h0001, 3'd0);
            if (!Stall) m_cnt = (m_cnt == 3'd4) ? 3'd0 : m_cnt + 3'd1;
            @(posedge Clk); #1;
            chk("stall_cnt", 100 + i, {13'd0, Cnt}, {13'd0, m_cnt});
        end
        chk("stall_ins", 160, Ins, 16'h0001);

        // HALT word with Done raised once Cnt reaches 2, found by a bounded wait.
        drive(0, 0, 0, 0, 0, 0, 16'hE001, 3'd0);
        budget = 0;
        while (Cnt != 3'd0 && budget < 10) begin
            @(posedge Clk); #1; budget++;
        end
        chk("wait_cnt0", 170, {13'd0, Cnt}, 16'd0);
        Buff_MEMIns = 1'b1;
        @(posedge Clk); #1;
        Buff_MEMIns = 1'b0;
        budget = 0;
        while (Cnt != 3'd2 && budget < 10) begin
            @(posedge Clk); #1; budget++;
        end
        chk("wait_cnt2", 171, {13'd0, Cnt}, 16'd2);
        Done = 1'b1;
        @(posedge Clk); #1;
        Done = 1'b0;
        chk("halt_flag", 172, {15'd0, Halted}, 16'd1);
        chk("halt_cnt", 173, {13'd0, Cnt}, 16'd2);
        repeat (3) @(posedge Clk);
        #1;
        chk("halt_hold", 174, {13'd0, Cnt}, 16'd2);
        chk("halt_run", 175, {15'd0, Running}, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
